alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Instruction fetch/decode sequencer. Drives the control side of the datapath ALU: opcode, S, SR_Cont, SR_Bit and Imm.
- Fetches 32-bit instructions over a req/ack handshake and drives register-file read/write addresses.
- Captures the ALU's N/Z/C/V outputs into an architectural flag register.
- Evaluates a 4-bit condition field per instruction; handles branch, halt and illegal opcodes.

Parameters:
- PC_W, 16, instruction word-address width.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req  out  1  fetch request.
- instr_addr  out  PC_W  word address of the fetch; equals pc.
- instr_ack  in  1  fetch data valid this cycle.
- instr_data  in  32  fetched instruction.
- opcode  out  4  ALU opcode.
- S  out  1  set-flags bit to the ALU.
- SR_Cont  out  3  shifter control to the ALU.
- SR_Bit  out  5  shift amount to the ALU.
- Imm  out  16  immediate to the ALU.
- rn_addr  out  4  register-file read port 1, feeds the ALU In1.
- rm_addr  out  4  register-file read port 2, feeds the ALU In2.
- rd_addr  out  4  register-file write address.
- rd_we  out  1  register-file write enable, one-cycle pulse.
- N, Z, C, V  in  1 each  ALU flag outputs.
- flags  out  4  architectural flag register {N,Z,C,V}.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  high in HALT.
- illegal  out  1  high when HALT was entered on an illegal opcode.

Behaviour:
- Reset values: pc=RST_PC, state=FETCH, flags=0. All of these outputs are 0: instr_req, rd_we, retired, halted, illegal, opcode, S, SR_Cont, SR_Bit, Imm, rn/rm/rd_addr.
- Reset mid-fetch or mid-EXEC: the next edge aborts the operation and no writeback occurs. instr_req drops one cycle after rst is sampled.
- Instruction formats: cond = [31:28], op = [27:24].
  - Register format: S=[23], SR_Cont=[22:20], SR_Bit=[19:15], rd=[14:11], rn=[10:7], rm=[6:3]; [2:0] ignored.
  - Immediate format, op=0110: rd=[23:20], Imm=[15:0]; S driven 0.
  - Branch, op=1011: signed 24-bit word offset [23:0].
  - Halt: op=1101.
  - Legal ALU ops: 0000-0111.
  - Illegal: 1000, 1001, 1010, 1100, 1110, 1111.
- Condition codes, evaluated against the flags register (not the live ALU outputs):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - instr_req=1, instr_addr=pc; held stable until instr_ack.
  - On the ack cycle: latch instr_data, drop req, go to DECODE.
  - instr_ack while not in FETCH is ignored.
- DECODE (1 cycle): register ALU control and address outputs from the latched instruction, then dispatch in this priority order:
  - Illegal op: HALT, illegal=1. Illegal is checked before cond, so it traps even if the cond fails.
  - Cond false: pc<=pc+1, retired=1, go to FETCH.
  - Halt op: HALT, retired=1, pc unchanged.
  - Branch: pc<=pc+1+sext(offset) truncated to PC_W (wraps modulo 2^PC_W), retired=1, go to FETCH.
  - Otherwise: go to EXEC.
- EXEC (1 cycle):
  - Control outputs held; the combinational ALU result settles.
  - Latch N/Z/C/V into a shadow register at the end of the cycle.
- WB (1 cycle):
  - rd_we=1 with rd_addr; the register file captures the ALU Out at this edge. Control outputs are still held.
  - If S=1, flags<=shadow; otherwise flags are unchanged.
  - pc<=pc+1 (wraps), retired=1, go to FETCH.
- Control outputs retain their last values outside DECODE through WB. rd_we is 0 in all states except WB.
- HALT: terminal; only rst exits. instr_req=0, rd_we=0, halted=1.
- Throughput: ALU instruction = fetch latency + 3 cycles; skipped, branch or halt instruction = fetch latency + 1 cycle.

Test Plan:
- Reset, then instruction 0xE0000000 | rd=1, rn=2, rm=3 (AL ADD, S=0); ack after 2 wait cycles -> instr_addr=0 held for 3 cycles; opcode=0000 in EXEC; rd_we pulse with rd_addr=1; flags stay 0; pc=1; retired pulses once.
- AL SUB with S=1, ALU returning Z=1, C=1 -> flags=0b0110 after WB. Next instruction cond=0 (EQ) executes; cond=1 (NE) skips with no rd_we and pc+1.
- Branch 0xEB FFFFFF at pc=5 -> pc=5 (pc+1-1), no rd_we. With PC_W=16, offset +2 at pc=0xFFFF -> pc=0x0002.
- MOVI 0xE6 5 0 1234 -> opcode=0110, Imm=0x1234, rd_addr=5, S=0, flags unchanged.
- Opcode 1110 with cond=F -> HALT, illegal=1, instr_req stays 0. Halt op 0xED000000 -> halted=1, illegal=0.
- Assert rst during EXEC of an S=1 instruction -> no rd_we, flags=0, pc=RST_PC, instr_req=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Instruction fetch/decode sequencer for the datapath ALU.
// It fetches over a req/ack handshake, evaluates conditions against the flag register, and drives ALU control and register-file addresses.
module alu_ctrl_seq #(
    parameter int              PC_W   = 16,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_ack,
    input  logic [31:0]     instr_data,
    output logic [3:0]      opcode,
    output logic            S,
    output logic [2:0]      SR_Cont,
    output logic [4:0]      SR_Bit,
    output logic [15:0]     Imm,
    output logic [3:0]      rn_addr,
    output logic [3:0]      rm_addr,
    output logic [3:0]      rd_addr,
    output logic            rd_we,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    output logic [3:0]      flags,
    output logic            retired,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_BR   = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1101;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_req;
    logic [3:0]      r_opcode;
    logic            r_s;
    logic [2:0]      r_sr_cont;
    logic [4:0]      r_sr_bit;
    logic [15:0]     r_imm;
    logic [3:0]      r_rn;
    logic [3:0]      r_rm;
    logic [3:0]      r_rd;
    logic            r_rd_we;
    logic [3:0]      r_flags;
    logic [3:0]      r_shadow;
    logic            r_retired;
    logic            r_halted;
    logic            r_illegal;

    logic [3:0]      w_op;
    logic            w_illegal_op;
    logic            w_cond_ok;
    logic [31:0]     w_br_sum;
    logic [PC_W-1:0] w_br_pc;
    logic [PC_W-1:0] w_pc_inc;

    assign w_op         = r_instr[27:24];
    assign w_illegal_op = w_op[3] && (w_op != OP_BR) && (w_op != OP_HALT);
    assign w_pc_inc     = r_pc + PC_W'(1);
    // Branch offset is a signed 24-bit word count; the target wraps at the PC width.
    assign w_br_sum     = 32'(r_pc) + 32'd1 + {{8{r_instr[23]}}, r_instr[23:0]};
    assign w_br_pc      = w_br_sum[PC_W-1:0];

    // Conditions use the architectural flags {N,Z,C,V}, never the live ALU outputs.
    always_comb begin
        w_cond_ok = 1'b0;
        case (r_instr[31:28])
            4'h0:    w_cond_ok = r_flags[2];
            4'h1:    w_cond_ok = !r_flags[2];
            4'h2:    w_cond_ok = r_flags[1];
            4'h3:    w_cond_ok = !r_flags[1];
            4'h4:    w_cond_ok = r_flags[3];
            4'h5:    w_cond_ok = !r_flags[3];
            4'h6:    w_cond_ok = r_flags[0];
            4'h7:    w_cond_ok = !r_flags[0];
            4'h8:    w_cond_ok = r_flags[1] && !r_flags[2];
            4'h9:    w_cond_ok = !r_flags[1] || r_flags[2];
            4'hA:    w_cond_ok = (r_flags[3] == r_flags[0]);
            4'hB:    w_cond_ok = (r_flags[3] != r_flags[0]);
            4'hC:    w_cond_ok = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'hD:    w_cond_ok = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RST_PC;
            r_instr   <= '0;
            r_req     <= 1'b0;
            r_opcode  <= '0;
            r_s       <= 1'b0;
            r_sr_cont <= '0;
            r_sr_bit  <= '0;
            r_imm     <= '0;
            r_rn      <= '0;
            r_rm      <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_flags   <= '0;
            r_shadow  <= '0;
            r_retired <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_retired <= 1'b0;
            r_rd_we   <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    // An ack only counts once the request is actually on the bus.
                    if (r_req && instr_ack) begin
                        r_instr <= instr_data;
                        r_req   <= 1'b0;
                        r_state <= ST_DECODE;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_opcode <= w_op;
                    if (w_op == OP_MOVI) begin
                        r_s       <= 1'b0;
                        r_sr_cont <= '0;
                        r_sr_bit  <= '0;
                        r_imm     <= r_instr[15:0];
                        r_rd      <= r_instr[23:20];
                        r_rn      <= '0;
                        r_rm      <= '0;
                    end else begin
                        r_s       <= r_instr[23];
                        r_sr_cont <= r_instr[22:20];
                        r_sr_bit  <= r_instr[19:15];
                        r_imm     <= '0;
                        r_rd      <= r_instr[14:11];
                        r_rn      <= r_instr[10:7];
                        r_rm      <= r_instr[6:3];
                    end
                    if (w_illegal_op) begin
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                        r_state   <= ST_HALT;
                    end else if (!w_cond_ok) begin
                        r_pc      <= w_pc_inc;
                        r_retired <= 1'b1;
                        r_req     <= 1'b1;
                        r_state   <= ST_FETCH;
                    end else if (w_op == OP_HALT) begin
                        r_halted  <= 1'b1;
                        r_retired <= 1'b1;
                        r_state   <= ST_HALT;
                    end else if (w_op == OP_BR) begin
                        r_pc      <= w_br_pc;
                        r_retired <= 1'b1;
                        r_req     <= 1'b1;
                        r_state   <= ST_FETCH;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_shadow <= {N, Z, C, V};
                    r_rd_we  <= 1'b1;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    if (r_s) begin
                        r_flags <= r_shadow;
                    end
                    r_pc      <= w_pc_inc;
                    r_retired <= 1'b1;
                    r_req     <= 1'b1;
                    r_state   <= ST_FETCH;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign instr_req  = r_req;
    assign instr_addr = r_pc;
    assign opcode     = r_opcode;
    assign S          = r_s;
    assign SR_Cont    = r_sr_cont;
    assign SR_Bit     = r_sr_bit;
    assign Imm        = r_imm;
    assign rn_addr    = r_rn;
    assign rm_addr    = r_rm;
    assign rd_addr    = r_rd;
    assign rd_we      = r_rd_we;
    assign flags      = r_flags;
    assign retired    = r_retired;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed and random instructions checked
// against an instruction-level model of pc, flags, writeback and halting.
module tb_alu_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic        instr_ack = 1'b0;
    logic [31:0] instr_data = '0;
    logic [3:0]  opcode;
    logic        S;
    logic [2:0]  SR_Cont;
    logic [4:0]  SR_Bit;
    logic [15:0] Imm;
    logic [3:0]  rn_addr, rm_addr, rd_addr;
    logic        rd_we;
    logic        N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
    logic [3:0]  flags;
    logic        retired, halted, illegal;

    int total = 0;
    int bad   = 0;
    int m_pc;
    logic [3:0] m_flags;

    alu_ctrl_seq dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .opcode(opcode), .S(S), .SR_Cont(SR_Cont), .SR_Bit(SR_Bit), .Imm(Imm),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .rd_addr(rd_addr), .rd_we(rd_we),
        .N(N), .Z(Z), .C(C), .V(V),
        .flags(flags), .retired(retired), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] reg_ins(input logic [3:0] cc, input logic [3:0] op,
                                            input logic s, input logic [2:0] src,
                                            input logic [4:0] sb, input logic [3:0] rd,
                                            input logic [3:0] rn, input logic [3:0] rm);
        return {cc, op, s, src, sb, rd, rn, rm, 3'b000};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({instr_req, rd_we, retired, halted, illegal, opcode, S, SR_Cont, SR_Bit, Imm} !== 0)
            fail("rst_ctrl", {instr_req, rd_we, retired, halted, illegal, opcode, S, SR_Cont, SR_Bit, Imm}, 0);
        total++;
        if ({rn_addr, rm_addr, rd_addr, flags, instr_addr} !== 0)
            fail("rst_addrs", {rn_addr, rm_addr, rd_addr, flags, instr_addr}, 0);
        rst = 1'b0;
        m_pc = 0;
        m_flags = 4'h0;
        @(negedge clk);
        total++;
        if (instr_req !== 1'b1) fail("rst_req_after", instr_req, 1);
        $display("reset done pc=%04h", m_pc);
    endtask

    task automatic do_instr(input logic [31:0] ins, input int lat, input logic [3:0] alu_f);
        logic [3:0] cnd, op, c_rd, c_op, exp_rd;
        logic       c_s, exp_s;
        logic [15:0] c_imm;
        logic [3:0] c_rn, c_rm;
        logic [2:0] c_src;
        logic [4:0] c_sb;
        int cls, k, we_n, ret_n, wait_n, off, pc0, exp_k, exp_we, exp_ret, exp_halt, exp_ill;
        cnd = ins[31:28];
        op  = ins[27:24];
        {N, Z, C, V} = alu_f;
        pc0 = m_pc;
        c_rd = '0; c_op = '0; c_s = 1'b0; c_imm = '0; c_rn = '0; c_rm = '0; c_src = '0; c_sb = '0;
        wait_n = 0;
        while (instr_req !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        total++;
        if (instr_req !== 1'b1) fail("fetch_req", instr_req, 1);
        total++;
        if (instr_addr !== 16'(m_pc)) fail("fetch_addr", instr_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            total++;
            if ({instr_req, instr_addr} !== {1'b1, 16'(m_pc)})
                fail("fetch_hold", {instr_req, instr_addr}, {1'b1, 16'(m_pc)});
        end
        instr_data = ins;
        instr_ack  = 1'b1;
        @(negedge clk);
        instr_ack  = 1'b0;
        instr_data = $urandom;
        total++;
        if (instr_req !== 1'b0) fail("req_drop", instr_req, 0);

        if (op inside {4'h8, 4'h9, 4'hA, 4'hC, 4'hE, 4'hF}) cls = 4;
        else if (!cond_ok(cnd, m_flags))                     cls = 1;
        else if (op == 4'hD)                                 cls = 2;
        else if (op == 4'hB)                                 cls = 3;
        else                                                 cls = 0;

        k = 1; we_n = 0; ret_n = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (rd_we === 1'b1) begin
                we_n++;
                c_rd = rd_addr; c_op = opcode; c_s = S; c_imm = Imm;
                c_rn = rn_addr; c_rm = rm_addr; c_src = SR_Cont; c_sb = SR_Bit;
            end
            if (retired === 1'b1) ret_n++;
            if (retired === 1'b1 || halted === 1'b1) break;
        end

        exp_k   = (cls == 0) ? 4 : 2;
        exp_we  = (cls == 0) ? 1 : 0;
        exp_ret = (cls == 4) ? 0 : 1;
        total++;
        if (k !== exp_k) fail("cycles", k, exp_k);
        total++;
        if (we_n !== exp_we) fail("we_count", we_n, exp_we);
        total++;
        if (ret_n !== exp_ret) fail("retire_count", ret_n, exp_ret);
        case (cls)
            0: begin
                exp_rd = (op == 4'h6) ? ins[23:20] : ins[14:11];
                exp_s  = (op == 4'h6) ? 1'b0 : ins[23];
                total++;
                if (c_rd !== exp_rd) fail("wb_rd", c_rd, exp_rd);
                total++;
                if (c_op !== op) fail("wb_op", c_op, op);
                total++;
                if (c_s !== exp_s) fail("wb_s", c_s, exp_s);
                if (op == 4'h6) begin
                    total++;
                    if (c_imm !== ins[15:0]) fail("wb_imm", c_imm, ins[15:0]);
                end else begin
                    total++;
                    if ({c_rn, c_rm, c_src, c_sb} !== {ins[10:7], ins[6:3], ins[22:20], ins[19:15]})
                        fail("wb_regs", {c_rn, c_rm, c_src, c_sb}, {ins[10:7], ins[6:3], ins[22:20], ins[19:15]});
                end
                if (exp_s) m_flags = alu_f;
                m_pc = (m_pc + 1) & 32'hFFFF;
            end
            1: m_pc = (m_pc + 1) & 32'hFFFF;
            3: begin
                off = int'(ins[23:0]);
                if (ins[23]) off = off - 32'h0100_0000;
                m_pc = (m_pc + 1 + off) & 32'hFFFF;
            end
            default: ;
        endcase
        exp_halt = (cls == 2 || cls == 4) ? 1 : 0;
        exp_ill  = (cls == 4) ? 1 : 0;
        total++;
        if (flags !== m_flags) fail("flags", flags, m_flags);
        total++;
        if (halted !== 1'(exp_halt)) fail("halted", halted, exp_halt);
        total++;
        if (illegal !== 1'(exp_ill)) fail("illegal", illegal, exp_ill);
        if (cls == 2 || cls == 4) begin
            for (int i = 0; i < 3; i++) begin
                instr_ack = (i == 1);
                @(negedge clk);
                total++;
                if ({instr_req, rd_we, retired, halted} !== 4'b0001)
                    fail("halt_quiet", {instr_req, rd_we, retired, halted}, 4'b0001);
            end
            instr_ack = 1'b0;
            total++;
            if (instr_addr !== 16'(m_pc)) fail("halt_pc", instr_addr, m_pc);
        end else begin
            total++;
            if ({instr_req, instr_addr} !== {1'b1, 16'(m_pc)})
                fail("next_pc", {instr_req, instr_addr}, {1'b1, 16'(m_pc)});
            @(negedge clk);
            total++;
            if ({retired, rd_we} !== 2'b00) fail("retire_pulse", {retired, rd_we}, 0);
        end
        $display("instr pc=%04h ins=%08h cls=%0d lat=%0d next_pc=%04h flags=%h", pc0, ins, cls, lat, m_pc, m_flags);
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  rop;
        int          sel;

        do_reset();
        do_instr(reg_ins(4'hE, 4'h0, 1'b0, 3'd0, 5'd0, 4'd1, 4'd2, 4'd3), 2, 4'b1111);
        do_instr(reg_ins(4'hE, 4'h1, 1'b1, 3'd2, 5'd7, 4'd4, 4'd5, 4'd6), 0, 4'b0110);
        do_instr(reg_ins(4'h0, 4'h0, 1'b0, 3'd0, 5'd0, 4'd7, 4'd1, 4'd2), 1, 4'b0000);
        do_instr(reg_ins(4'h1, 4'h0, 1'b1, 3'd0, 5'd0, 4'd7, 4'd1, 4'd2), 0, 4'b0000);

        do_reset();
        do_instr({4'hE, 4'hB, 24'd4}, 0, 4'h0);
        do_instr(32'hEBFF_FFFF, 1, 4'h0);
        do_instr({4'hE, 4'hB, 24'h00FFF9}, 0, 4'h0);
        do_instr({4'hE, 4'hB, 24'd2}, 2, 4'h0);
        do_instr(32'hE650_1234, 0, 4'b1010);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                rop = 4'(sel);
                ins = $urandom;
                ins[27:24] = rop;
            end else begin
                ins = $urandom;
                ins[27:24] = 4'hB;
            end
            do_instr(ins, $urandom_range(0, 3), 4'($urandom_range(0, 15)));
        end

        do_instr(32'hFE00_0000, 0, 4'h0);

        do_reset();
        do_instr(32'hED00_0000, 1, 4'h0);

        do_reset();
        do_instr(reg_ins(4'hF, 4'h2, 1'b1, 3'd0, 5'd0, 4'd3, 4'd3, 4'd3), 0, 4'h0);
        {N, Z, C, V} = 4'b1111;
        instr_data = reg_ins(4'hE, 4'h3, 1'b1, 3'd1, 5'd1, 4'd9, 4'd8, 4'd7);
        instr_ack  = 1'b1;
        @(negedge clk);
        instr_ack  = 1'b0;
        @(negedge clk);
        total++;
        if ({opcode, S, rd_we} !== {4'h3, 1'b1, 1'b0})
            fail("exec_op", {opcode, S, rd_we}, {4'h3, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_we, flags, instr_req, instr_addr} !== 0)
            fail("abort_state", {rd_we, flags, instr_req, instr_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({instr_req, rd_we, flags, instr_addr} !== {1'b1, 1'b0, 4'h0, 16'h0000})
            fail("abort_resume", {instr_req, rd_we, flags, instr_addr}, {1'b1, 1'b0, 4'h0, 16'h0000});
        $display("reset-in-exec abort pc=%04h", instr_addr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
